// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and the ShiftRows byte-placement helper.
package aes_pkg;

    localparam int unsigned STATE_W = 128;
    localparam int unsigned NBYTES  = 16;
    localparam int unsigned CNT_W   = $clog2(NBYTES);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    // Byte r+4c lands at r+4((c-r) mod 4); the 2-bit subtract wraps mod 4 for free.
    function automatic logic [CNT_W-1:0] shift_dest(input logic [CNT_W-1:0] idx);
        logic [1:0] row;
        logic [1:0] col;
        logic [1:0] new_col;
        row     = idx[1:0];
        col     = idx[3:2];
        new_col = col - row;
        return {new_col, row};
    endfunction

endpackage

// File: rtl/sbox.sv
// Combinational FIPS-197 AES S-box; table entry 0 sits in the top byte.
module sbox (
    input  logic [7:0] addr,
    output logic [7:0] result
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign result = SBOX_TABLE[{~addr, 3'b000} +: 8];

endmodule

// File: rtl/sub_shift_stage.sv
// Byte-serial AES SubBytes (+ optional ShiftRows): one state every 18 cycles via a single S-box.
module sub_shift_stage
    import aes_pkg::*;
#(
    parameter int unsigned SHIFT_ROWS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   dest;
    logic [STATE_W-1:0] data_q;
    logic [STATE_W-1:0] result_q;
    logic [7:0]         sbox_in;
    logic [7:0]         sbox_out;
    logic               accept;

    assign accept = in_valid && (state_q == StIdle);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StBusy;
            StBusy:  if (cnt_q == CNT_W'(NBYTES - 1)) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Byte i lives at bit offset 8*(15-i), and 15-i is just ~i for a 4-bit index.
    assign sbox_in = data_q[{~cnt_q, 3'b000} +: 8];
    assign dest    = (SHIFT_ROWS != 0) ? shift_dest(cnt_q) : cnt_q;

    sbox u_sbox (
        .addr   (sbox_in),
        .result (sbox_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            data_q   <= '0;
            result_q <= '0;
        end else if (accept) begin
            cnt_q  <= '0;
            data_q <= in_data;
        end else if (state_q == StBusy) begin
            result_q[{~dest, 3'b000} +: 8] <= sbox_out;
            cnt_q                          <= cnt_q + CNT_W'(1);
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StBusy);
    assign out_valid = (state_q == StDone);
    assign out_data  = out_valid ? result_q : '0;

endmodule

// File: tb/tb_sub_shift_stage.sv
// Randomized self-checking bench for sub_shift_stage, both SHIFT_ROWS settings side by side.
module tb_sub_shift_stage;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;

    logic         sr_in_ready, sr_out_valid, sr_busy;
    logic [127:0] sr_out_data;
    logic         ns_in_ready, ns_out_valid, ns_busy;
    logic [127:0] ns_out_data;

    int total = 0;
    int bad = 0;

    localparam logic [127:0] VEC_IN = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] VEC_SR = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] VEC_NS = 128'hd42711aee0bf98f1b8b45de51e415230;

    always #5 clk = ~clk;

    sub_shift_stage #(.SHIFT_ROWS(1)) dut_sr (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (sr_in_ready),
        .in_data   (in_data),
        .out_valid (sr_out_valid),
        .out_ready (out_ready),
        .out_data  (sr_out_data),
        .busy      (sr_busy)
    );

    sub_shift_stage #(.SHIFT_ROWS(0)) dut_ns (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (ns_in_ready),
        .in_data   (in_data),
        .out_valid (ns_out_valid),
        .out_ready (out_ready),
        .out_data  (ns_out_data),
        .busy      (ns_busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference S-box derived from GF(2^8) inversion plus the affine map.
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, a);
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] xform(input logic [127:0] d, input bit sr);
        logic [127:0] o;
        int dd;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            dd = sr ? ((i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4)) : i;
            o[127 - 8 * dd -: 8] = sb[d[127 - 8 * i -: 8]];
        end
        return o;
    endfunction

    // Transaction-level model: idle -> 16 edges of work -> result held until taken.
    bit           m_idle = 1'b1;
    int           m_left = 0;
    bit           m_valid = 1'b0;
    logic [127:0] m_exp_sr = '0;
    logic [127:0] m_exp_ns = '0;
    int           cycle_cnt = 0;
    int           acc_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle  <= 1'b1;
            m_left  <= 0;
            m_valid <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 1;
            if (m_idle && in_valid) begin
                m_idle   <= 1'b0;
                m_left   <= 16;
                m_exp_sr <= xform(in_data, 1'b1);
                m_exp_ns <= xform(in_data, 1'b0);
                acc_q.push_back(cycle_cnt + 1);
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_valid <= 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
                m_idle  <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("sr_in_ready", 128'(sr_in_ready), 128'(m_idle));
        chk("sr_busy", 128'(sr_busy), 128'(m_left > 0));
        chk("sr_out_valid", 128'(sr_out_valid), 128'(m_valid));
        chk("sr_out_data", sr_out_data, m_valid ? m_exp_sr : 128'h0);
        chk("ns_in_ready", 128'(ns_in_ready), 128'(m_idle));
        chk("ns_busy", 128'(ns_busy), 128'(m_left > 0));
        chk("ns_out_valid", 128'(ns_out_valid), 128'(m_valid));
        chk("ns_out_data", ns_out_data, m_valid ? m_exp_ns : 128'h0);
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_job(input logic [127:0] data, input int hold,
                           output logic [127:0] got_sr, output logic [127:0] got_ns);
        int n;
        int acc_before;
        logic [127:0] s_sr;
        logic [127:0] s_ns;
        got_sr = '0;
        got_ns = '0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = data;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = rnd128();
        n = 0;
        while (!sr_out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!sr_out_valid) begin
            total++;
            bad++;
            $display("FAIL job_timeout: got out_valid=0 want 1 within 40 cycles");
            return;
        end
        chk("latency", 128'(cycle_cnt - acc_q[$]), 128'd16);
        s_sr = sr_out_data;
        s_ns = ns_out_data;
        acc_before = acc_q.size();
        for (int k = 0; k < hold; k++) begin
            in_valid = ~in_valid;
            in_data  = rnd128();
            @(negedge clk);
            chk("hold_data_sr", sr_out_data, s_sr);
            chk("hold_data_ns", ns_out_data, s_ns);
            chk("hold_in_ready", 128'(sr_in_ready), 128'd0);
        end
        in_valid = 1'b0;
        chk("no_second_accept", 128'(acc_q.size()), 128'(acc_before));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ready_after_handshake", 128'(sr_in_ready), 128'd1);
        got_sr = s_sr;
        got_ns = s_ns;
    endtask

    initial begin
        logic [127:0] r_sr;
        logic [127:0] r_ns;
        int n;

        for (int a = 0; a < 256; a++) sb[a] = sbox_calc(8'(a));
        chk("model_sbox_00", 128'(sb[8'h00]), 128'h63);
        chk("model_sbox_53", 128'(sb[8'h53]), 128'hed);
        chk("model_sbox_ff", 128'(sb[8'hff]), 128'h16);
        chk("model_vec_sr", xform(VEC_IN, 1'b1), VEC_SR);
        chk("model_vec_ns", xform(VEC_IN, 1'b0), VEC_NS);

        #2 rst_n = 1'b0;
        #10;
        chk("reset_in_ready", 128'(sr_in_ready), 128'd1);
        chk("reset_out_valid", 128'(sr_out_valid), 128'd0);
        chk("reset_out_data", sr_out_data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_job(128'h0, 0, r_sr, r_ns);
        chk("zero_in_sr", r_sr, {16{8'h63}});

        run_job(VEC_IN, 0, r_sr, r_ns);
        chk("vec_sr", r_sr, VEC_SR);
        chk("vec_ns", r_ns, VEC_NS);

        run_job(VEC_IN, 5, r_sr, r_ns);
        chk("vec_hold_sr", r_sr, VEC_SR);
        chk("vec_hold_ns", r_ns, VEC_NS);

        // Abort mid-operation at cnt=7.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = rnd128();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(sr_busy), 128'd0);
        chk("abort_in_ready", 128'(sr_in_ready), 128'd1);
        chk("abort_out_valid", 128'(ns_out_valid), 128'd0);
        chk("abort_out_data", sr_out_data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run_job(VEC_IN, 0, r_sr, r_ns);
        chk("after_abort_sr", r_sr, VEC_SR);
        chk("after_abort_ns", r_ns, VEC_NS);

        // Back-to-back random states with the sink always ready.
        @(negedge clk);
        acc_q.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        n = 0;
        while (acc_q.size() < 16 && n < 16 * 18 + 40) begin
            in_data = rnd128();
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        repeat (24) @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_accepts", 128'(acc_q.size()), 128'd16);
        for (int i = 1; i < acc_q.size(); i++) begin
            chk("b2b_spacing", 128'(acc_q[i] - acc_q[i - 1]), 128'd18);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sub_shift_stage.md
SUB_SHIFT_STAGE -- requirements
Module: sub_shift_stage

Interface
REQ-001 SHALL have parameter: SHIFT_ROWS, 1, 1 = apply ShiftRows after SubBytes; 0 = SubBytes only.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  in_data holds a state to process.
REQ-005 SHALL have port: in_ready  output  1  block can accept a state.
REQ-006 SHALL have port: in_data  input  128  AES state; byte i = bits [127-8i : 120-8i]; byte r+4c = row r, column c.
REQ-007 SHALL have port: out_valid  output  1  out_data holds a finished state.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts out_data.
REQ-009 SHALL have port: out_data  output  128  transformed state, same byte ordering as in_data.
REQ-010 SHALL have port: busy  output  1  high in BUSY state.

Function
REQ-011 SHALL use a 3-state FSM: IDLE, BUSY, DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE; in_valid SHALL be ignored in BUSY and DONE.
REQ-013 In IDLE, in_valid&&in_ready SHALL capture in_data into an internal state register, clear the 4-bit byte counter to 0, and go to BUSY.
REQ-014 In BUSY, each cycle SHALL present byte[cnt] to one sbox instance and write the result into result byte dest(cnt), then increment cnt.
REQ-015 dest(i) SHALL be i when SHIFT_ROWS=0; when SHIFT_ROWS=1, input byte r+4c SHALL go to output byte r+4((c-r) mod 4).
REQ-016 On the BUSY cycle with cnt=15, the FSM SHALL go to DONE; the counter SHALL wrap to 0.
REQ-017 Latency: out_valid SHALL rise exactly 16 clock edges after the accepting edge.
REQ-018 In DONE, out_valid=1 and out_data SHALL be stable until out_valid&&out_ready, then the FSM SHALL return to IDLE.
REQ-019 If out_ready is already high when DONE is entered, the transfer SHALL complete on that first DONE cycle; the next accept SHALL be possible on the following cycle (throughput one state per 18 cycles).
REQ-020 out_data SHALL be driven from the result register only; it SHALL read 0 outside DONE.
REQ-021 The sbox mapping SHALL equal the FIPS-197 S-box for all 256 inputs.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, cnt=0, state and result registers=0, out_valid=0, busy=0, in_ready=1.
REQ-023 Reset asserted in BUSY or DONE SHALL abort the operation; no partial result SHALL appear after release.
REQ-024 After release, the first rising edge with in_valid=1 SHALL be a legal accept.

Structure
REQ-025 Package aes_pkg SHALL hold: STATE_W=128, NBYTES=16, the FSM state enum, and the ShiftRows destination-index function.
REQ-026 The block SHALL instantiate exactly one sub-module, sbox (8-bit addr in, 8-bit result out, combinational).
REQ-027 Estimated size: 150-250 lines RTL, excluding sbox.

Verification
REQ-028 Reset, then in_data=0, SHIFT_ROWS=1 -> out_valid after 16 edges, out_data=0x63 repeated in all 16 bytes.
REQ-029 SHIFT_ROWS=1, in_data=193de3bea0f4e22b9ac68d2ae9f84808 -> out_data=d4bf5d30e0b452aeb84111f11e2798e5.
REQ-030 SHIFT_ROWS=0, same input -> out_data=d42711aee0bf98f1b8b45de51e415230.
REQ-031 Hold out_ready=0 for 5 cycles in DONE, toggle in_valid -> out_data stable, in_ready=0, no second accept; one cycle after the handshake, in_ready=1.
REQ-032 Assert rst_n low at cnt=7 in BUSY -> all outputs reset immediately; a new state accepted after release yields the correct result.
REQ-033 Run 16 back-to-back random states with out_ready=1 -> results match the reference model; the accept-to-accept spacing is 18 cycles.
